// File: rtl/fft_stage_collect_if.sv
// fft_stage_collect_if: beat input and frame output handshakes of the FFT stage collector.
interface fft_stage_collect_if #(
    parameter int W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_slot;
    logic [8*W-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic [32*W-1:0] out_data;
    logic            err_slot;
    logic [7:0]      frame_count;
    modport slave (
        input  in_valid, in_slot, in_data, out_ready,
        output in_ready, out_valid, out_data, err_slot, frame_count
    );
    modport master (
        output in_valid, in_slot, in_data, out_ready,
        input  in_ready, out_valid, out_data, err_slot, frame_count
    );
endinterface

// File: rtl/fft_stage_collect.sv
// fft_stage_collect: scatters 8-lane MAC beats into ping-pong 32-word frames and hands them out.
module fft_stage_collect #(
    parameter int W            = 64,
    parameter bit STRICT_ORDER = 1'b1
) (
    input logic               clk,
    input logic               reset,
    fft_stage_collect_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_state_e;
    buf_state_e st_q [2];
    buf_state_e st_d [2];
    logic [W-1:0] mem_q [2][32];
    logic       wr_sel_q, rd_sel_q, in_ready_q, err_q;
    logic       wr_sel_d, in_ready_d, err_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] fc_q, fc_d;
    logic       accept, in_order, wr_en, complete, out_valid, pop;
    // cnt_q is the expected slot in strict mode and the accepted-beat count in loose mode;
    // either way the beat that finds it at 3 closes the frame.
    always_comb begin
        accept     = bus.in_valid && in_ready_q;
        in_order   = !STRICT_ORDER || bus.in_slot == cnt_q;
        wr_en      = accept && in_order;
        complete   = wr_en && cnt_q == 2'd3;
        out_valid  = st_q[rd_sel_q] == FULL;
        pop        = out_valid && bus.out_ready;
        st_d       = st_q;
        if (wr_en) st_d[wr_sel_q] = complete ? FULL : FILLING;
        if (pop) st_d[rd_sel_q] = EMPTY;
        wr_sel_d   = wr_sel_q ^ complete;
        cnt_d      = wr_en ? cnt_q + 2'd1 : cnt_q;
        err_d      = accept && !in_order;
        fc_d       = fc_q + {7'd0, pop};
        // Ready only rises once the freed buffer has been EMPTY for a full edge.
        in_ready_d = st_q[wr_sel_q] != FULL && st_d[wr_sel_d] != FULL;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= '{EMPTY, EMPTY};
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
            fc_q       <= 8'd0;
        end else begin
            st_q       <= st_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_q ^ pop;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
            fc_q       <= fc_d;
        end
    end
    // Lane l = {m, out2}: word = m[1]*16 + out2*8 + m[0]*4 + slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < 32; k++)
                    mem_q[b][k] <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < 8; l++)
                mem_q[wr_sel_q][{l[2], l[0], l[1], bus.in_slot}] <= bus.in_data[l*W +: W];
        end
    end
    for (genvar k = 0; k < 32; k++) begin : g_out
        assign bus.out_data[k*W +: W] = mem_q[rd_sel_q][k];
    end
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid;
    assign bus.err_slot    = err_q;
    assign bus.frame_count = fc_q;
endmodule
